// File: rtl/jt1943_romcache_pkg.sv
// Shared types and helpers for the jt1943 ROM read cache.
package jt1943_romcache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Number of low consumer-address bits that select inside a 32-bit line.
  function automatic int drop_bits(input int dw);
    case (dw)
      8:       return 2;
      16:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/jt1943_romcache_line.sv
// One cache line: tag, valid bit and 32-bit data, plus tag match.
module jt1943_romcache_line #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] tag_in,
  input  logic [31:0]   din,
  input  logic [AW-1:0] line_addr,
  output logic          match,
  output logic [31:0]   data
);

  logic          valid_r;
  logic [AW-1:0] tag_r;

  // Load the line on a fill strobe; reset clears the valid bit and contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      data    <= 32'h0000_0000;
    end else if (we) begin
      valid_r <= 1'b1;
      tag_r   <= tag_in;
      data    <= din;
    end
  end

  assign match = valid_r && (tag_r == line_addr);

endmodule

// File: rtl/jt1943_romcache.sv
// N-entry fully associative ROM read cache in front of a 32-bit SDRAM burst port.
// Optional hit/miss statistics are built when JT1943_ROMCACHE_STATS_EN is defined.
module jt1943_romcache
  import jt1943_romcache_pkg::*;
#(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int ENTRIES   = 4,
  parameter int INVERT_A0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  input  logic [31:0]   din,
  input  logic          we,
  output logic          req,
  output logic [AW-1:0] addr_req,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int            PW    = $clog2(ENTRIES);
  localparam int            DROP  = drop_bits(DW);
  localparam logic [AW-1:0] LMASK = ~((AW'(1) << DROP) - AW'(1));

  state_t                state_r;
  logic [PW-1:0]         ptr_r;
  logic [AW-1:0]         line_addr_s;
  logic [ENTRIES-1:0]    match_s;
  logic [ENTRIES-1:0]    wr_s;
  logic [31:0]           data_s [ENTRIES];
  logic [31:0]           line_s;
  logic                  hit_s;
  logic [1:0]            sel_s;
  logic [DW-1:0]         word_s;
  logic                  fill_s;
  logic                  miss_s;

  assign line_addr_s = addr & LMASK;
  assign fill_s      = cen && (state_r == WAIT) && we;
  assign miss_s      = cen && (state_r == IDLE) && addr_ok && !hit_s;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_line
      assign wr_s[gi] = fill_s && (ptr_r == PW'(gi));
      jt1943_romcache_line #(.AW(AW)) u_line (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_s[gi]),
        .tag_in    (addr_req),
        .din       (din),
        .line_addr (line_addr_s),
        .match     (match_s[gi]),
        .data      (data_s[gi])
      );
    end
  endgenerate

  // One-hot OR mux: fills only happen on misses, so at most one line matches.
  always_comb begin
    hit_s  = 1'b0;
    line_s = 32'h0000_0000;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match_s[i]) begin
        hit_s  = 1'b1;
        line_s = line_s | data_s[i];
      end else begin
        line_s = line_s;
      end
    end
  end

  assign sel_s = {addr[1], (INVERT_A0 != 0) ? ~addr[0] : addr[0]};

  // Pick the byte/half/long inside the hit line; INVERT_A0 serves byte-swapped ROMs.
  always_comb begin
    word_s = '0;
    if (DW == 8) begin
      word_s = DW'(line_s >> {sel_s, 3'b000});
    end else if (DW == 16) begin
      word_s = DW'(line_s >> {sel_s[0], 4'b0000});
    end else begin
      word_s = DW'(line_s);
    end
  end

  // Request FSM, victim pointer and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      req      <= 1'b0;
      addr_req <= '0;
      dout     <= '0;
      data_ok  <= 1'b0;
    end else if (cen) begin
      data_ok <= addr_ok && hit_s;
      if (addr_ok && hit_s) begin
        dout <= word_s;
      end
      case (state_r)
        IDLE: begin
          if (addr_ok && !hit_s) begin
            addr_req <= line_addr_s;
            req      <= 1'b1;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (we) begin
            ptr_r   <= ptr_r + PW'(1);
            req     <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          req     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef JT1943_ROMCACHE_STATS_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // Saturating hit/miss statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 16'h0000;
      miss_cnt_r <= 16'h0000;
    end else if (cen) begin
      if (addr_ok && hit_s && (hit_cnt_r != 16'hFFFF)) begin
        hit_cnt_r <= hit_cnt_r + 16'h0001;
      end
      if (miss_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'h0001;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_jt1943_romcache.sv
// Scoreboard bench for jt1943_romcache: default DUT (DW=8, 4 entries) plus
// two side instances (DW=8 byte-swapped, DW=16) checked on the first line.
module tb_jt1943_romcache;

  localparam int AW = 18;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cen;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic [31:0]   din;
  logic          we;

  logic          req, data_ok;
  logic [AW-1:0] addr_req;
  logic [7:0]    dout;
  logic [15:0]   hit_cnt, miss_cnt;

  logic          req_i, data_ok_i;
  logic [AW-1:0] addr_req_i;
  logic [7:0]    dout_i;
  logic [15:0]   hit_cnt_i, miss_cnt_i;

  logic          req_w, data_ok_w;
  logic [AW-1:0] addr_req_w;
  logic [15:0]   dout_w;
  logic [15:0]   hit_cnt_w, miss_cnt_w;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  jt1943_romcache #(.AW(AW), .DW(8), .ENTRIES(4), .INVERT_A0(0)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .addr_ok(addr_ok),
    .din(din), .we(we), .req(req), .addr_req(addr_req), .dout(dout),
    .data_ok(data_ok), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  jt1943_romcache #(.AW(AW), .DW(8), .ENTRIES(4), .INVERT_A0(1)) u_inv (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .addr_ok(addr_ok),
    .din(din), .we(we), .req(req_i), .addr_req(addr_req_i), .dout(dout_i),
    .data_ok(data_ok_i), .hit_cnt(hit_cnt_i), .miss_cnt(miss_cnt_i)
  );

  jt1943_romcache #(.AW(AW), .DW(16), .ENTRIES(2), .INVERT_A0(0)) u_w16 (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .addr_ok(addr_ok),
    .din(din), .we(we), .req(req_w), .addr_req(addr_req_w), .dout(dout_w),
    .data_ok(data_ok_w), .hit_cnt(hit_cnt_w), .miss_cnt(miss_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return {31'd0, req};
      1:       return {14'd0, addr_req};
      2:       return {24'd0, dout};
      3:       return {31'd0, data_ok};
      4:       return {16'd0, hit_cnt};
      5:       return {16'd0, miss_cnt};
      6:       return {24'd0, dout_i};
      7:       return {31'd0, data_ok_i};
      8:       return {16'd0, dout_w};
      9:       return {31'd0, data_ok_w};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic push_reset_state(input string tag);
    push({tag, "_req"}, 0, 32'd0);
    push({tag, "_addr_req"}, 1, 32'd0);
    push({tag, "_dout"}, 2, 32'd0);
    push({tag, "_data_ok"}, 3, 32'd0);
    push({tag, "_hit_cnt"}, 4, 32'd0);
    push({tag, "_miss_cnt"}, 5, 32'd0);
  endtask

  // Miss on line a, then complete it with data d; leaves addr_ok low.
  task automatic fill(input logic [AW-1:0] a, input logic [31:0] d);
    addr = a; addr_ok = 1'b1; we = 1'b0;
    push("fill_req", 0, 32'd1);
    push("fill_addr_req", 1, {14'd0, a});
    push("fill_ok0", 3, 32'd0);
    step();
    we = 1'b1; din = d;
    push("fill_we_req", 0, 32'd0);
    push("fill_we_ok", 3, 32'd0);
    step();
    we = 1'b0; addr_ok = 1'b0;
    push("fill_idle_req", 0, 32'd0);
    step();
  endtask

  initial begin
    int exp_hit;
    int exp_miss;
    rst = 1'b1; cen = 1'b1; addr = '0; addr_ok = 1'b0; din = 32'd0; we = 1'b0;
    push_reset_state("reset");
    step();
    rst = 1'b0;

    // First miss and fill, sub-word selection on all three instances
    addr = 18'h00010; addr_ok = 1'b1;
    push("miss_req", 0, 32'd1);
    push("miss_addr_req", 1, 32'h10);
    push("miss_ok", 3, 32'd0);
    step();
    we = 1'b1; din = 32'h44332211;
    push("we_req", 0, 32'd0);
    push("we_ok", 3, 32'd0);
    step();
    we = 1'b0;
    push("hit10_ok", 3, 32'd1);
    push("hit10_dout", 2, 32'h11);
    push("inv10_dout", 6, 32'h22);
    push("w16_10_dout", 8, 32'h2211);
    step();
    addr = 18'h00011;
    push("hit11_dout", 2, 32'h22);
    push("inv11_dout", 6, 32'h11);
    push("w16_11_dout", 8, 32'h4433);
    push("w16_11_ok", 9, 32'd1);
    step();
    addr = 18'h00012;
    push("hit12_dout", 2, 32'h33);
    push("inv12_dout", 6, 32'h44);
    push("inv12_ok", 7, 32'd1);
    push("w16_12_ok", 9, 32'd0);
    push("w16_12_hold", 8, 32'h4433);
    step();
    addr = 18'h00013;
    push("hit13_dout", 2, 32'h44);
    push("hit13_ok", 3, 32'd1);
    step();

    // Clock enable low freezes everything
    cen = 1'b0; addr = 18'h00010;
    push("cen0_dout", 2, 32'h44);
    push("cen0_ok", 3, 32'd1);
    step();
    addr_ok = 1'b0;
    push("cen0_ok_hold", 3, 32'd1);
    step();
    cen = 1'b1;
    push("noaddr_ok", 3, 32'd0);
    push("noaddr_dout", 2, 32'h44);
    push("noaddr_req", 0, 32'd0);
    step();

    // Round-robin replacement: E evicts A, B still hits
    fill(18'h00020, 32'hB3B2B1B0);
    fill(18'h00030, 32'hC3C2C1C0);
    fill(18'h00040, 32'hD3D2D1D0);
    fill(18'h00050, 32'hE3E2E1E0);
    addr = 18'h00021; addr_ok = 1'b1;
    push("B_hit_ok", 3, 32'd1);
    push("B_hit_dout", 2, 32'hB1);
    push("B_hit_noreq", 0, 32'd0);
    step();
    addr = 18'h00010;
    push("A_evicted_req", 0, 32'd1);
    push("A_evicted_addr_req", 1, 32'h10);
    push("A_miss_hold", 2, 32'hB1);
    step();
    we = 1'b1; din = 32'hA3A2A1A0;
    push("A_we_req", 0, 32'd0);
    step();
    we = 1'b0;
    push("A_refill_ok", 3, 32'd1);
    push("A_refill_dout", 2, 32'hA0);
    step();

    // Address changes during WAIT; B was the next victim
    addr = 18'h00020;
    push("B_evicted_req", 0, 32'd1);
    push("B_evicted_addr_req", 1, 32'h20);
    step();
    addr = 18'h00070;
    push("wait_frozen_addr_req", 1, 32'h20);
    push("wait_frozen_req", 0, 32'd1);
    push("wait_miss_ok", 3, 32'd0);
    step();
    addr = 18'h00031;
    push("wait_other_hit_ok", 3, 32'd1);
    push("wait_other_hit_dout", 2, 32'hC1);
    push("wait_other_hit_req", 0, 32'd1);
    step();
    addr = 18'h00070; we = 1'b1; din = 32'hB3B2B1B0;
    push("wait_we_req", 0, 32'd0);
    push("wait_we_addr_req", 1, 32'h20);
    push("wait_we_ok", 3, 32'd0);
    step();
    we = 1'b0;
    push("new_miss_req", 0, 32'd1);
    push("new_miss_addr_req", 1, 32'h70);
    step();
    addr = 18'h00022;
    push("orig_cached_ok", 3, 32'd1);
    push("orig_cached_dout", 2, 32'hB2);
    step();
    addr = 18'h00030;
    push("C_evicted_ok", 3, 32'd0);
    push("C_evicted_dout", 2, 32'hB2);
    step();

    // Reset while waiting aborts the request; a late we is ignored
    rst = 1'b1; addr_ok = 1'b0;
    push_reset_state("rst_wait");
    step();
    rst = 1'b0; we = 1'b1; din = 32'h12345678;
    push("late_we_req", 0, 32'd0);
    push("late_we_ok", 3, 32'd0);
    step();
    we = 1'b0; addr = 18'h00022; addr_ok = 1'b1;
    push("post_rst_invalid_ok", 3, 32'd0);
    push("post_rst_req", 0, 32'd1);
    push("post_rst_addr_req", 1, 32'h20);
    step();
    we = 1'b1; din = 32'hB3B2B1B0;
    push("stats_we_req", 0, 32'd0);
    step();
    we = 1'b0; addr_ok = 1'b0;
    step();
    fill(18'h00070, 32'h73727170);
    fill(18'h00080, 32'h83828180);

    // Five hit cycles
    addr_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] exp_b;
      addr = (i < 4) ? (18'h00020 + AW'(i)) : 18'h00070;
      exp_b = (i < 4) ? (8'hB0 + 8'(i)) : 8'h70;
      push("stats_hit_ok", 3, 32'd1);
      push("stats_hit_dout", 2, {24'd0, exp_b});
      step();
    end
    addr_ok = 1'b0;
`ifdef JT1943_ROMCACHE_STATS_EN
    exp_hit = 5; exp_miss = 3;
`else
    exp_hit = 0; exp_miss = 0;
`endif
    push("hit_cnt", 4, 32'(exp_hit));
    push("miss_cnt", 5, 32'(exp_miss));
    step();

`ifdef JT1943_ROMCACHE_STATS_EN
    addr = 18'h00020; addr_ok = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      step();
    end
    addr_ok = 1'b0;
    push("hit_cnt_sat", 4, 32'h0000FFFF);
    push("miss_cnt_after_sat", 5, 32'd3);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
